// File: rtl/collision_game_ctrl_pkg.sv
// Shared types and defaults for the collision/game controller slice.
// Latency: none (package only).
// Backpressure: none.
//  Contents: game state encoding, default box sizes and game constants,
//  visible screen limits, BCD score increment helper.
package collision_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int CAR_W_DEF        = 50;
    localparam int CAR_H_DEF        = 80;
    localparam int OBS_W_DEF        = 50;
    localparam int OBS_H_DEF        = 80;
    localparam int LIVES_INIT_DEF   = 3;
    localparam int CRASH_FRAMES_DEF = 60;
    localparam int SCORE_MAX_DEF    = 9999;

    // Visible area of the 640x480 raster the positions live in.
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [15:0] BCD_SCORE_MAX = 16'h9999;

    // Four-digit BCD increment with per-digit carry, saturating at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != BCD_SCORE_MAX) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/collision_game_ctrl_if.sv
// Bundle between position blocks / HUD and the game controller.
// Latency: wires only.
// Backpressure: none; positions are level signals, frame_tick is a pulse.
//  slave  : the game controller (consumes positions, drives game status)
//  master : the surrounding system / testbench
interface collision_game_ctrl_if;
    logic        frame_tick;
    logic        start_n;
    logic [9:0]  car_h_pos;
    logic [8:0]  car_v_pos;
    logic [9:0]  obs_h_pos;
    logic [8:0]  obs_v_pos;
    logic        obs_valid;
    logic        reset_game;
    logic        game_over;
    logic        crash_flash;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [1:0]  state;

    modport slave (
        input  frame_tick, start_n, car_h_pos, car_v_pos,
               obs_h_pos, obs_v_pos, obs_valid,
        output reset_game, game_over, crash_flash, lives, score, state
    );

    modport master (
        output frame_tick, start_n, car_h_pos, car_v_pos,
               obs_h_pos, obs_v_pos, obs_valid,
        input  reset_game, game_over, crash_flash, lives, score, state
    );
endinterface

// File: rtl/collision_game_ctrl_key_edge_detect.sv
// Push-button synchroniser with falling-edge (press) pulse; reused per key.
// Latency: key_press is high for one cycle, 3 cycles after key_n falls.
// Backpressure: none; every press edge yields exactly one pulse.
//  Ports: iVGA_CLK clock, iRST sync active-high reset,
//         key_n async active-low button, key_press one-cycle press pulse.
module key_edge_detect (
    input  logic iVGA_CLK,
    input  logic iRST,
    input  logic key_n,
    output logic key_press
);
    // [0],[1] form the synchroniser; [2] is the previous synchronised value.
    logic [2:0] sync_q;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            sync_q    <= 3'b111;
            key_press <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], key_n};
            key_press <= sync_q[2] & ~sync_q[1];
        end
    end
endmodule

// File: rtl/collision_game_ctrl.sv
// Per-frame car/obstacle collision check and game FSM (lives, score, car reset).
// Latency: frame_tick / start_press effects are visible one cycle later.
// Backpressure: none; every frame_tick is consumed in the cycle it arrives.
//  Ports: iVGA_CLK clock, iRST sync active-high reset, bus (slave modport):
//   frame_tick, start_n, car/obs positions, obs_valid in;
//   reset_game, game_over, crash_flash, lives, score, state out.
//  Option: define SCORE_BCD_EN for a 4-digit BCD score saturating at 9999.
module collision_game_ctrl
    import collision_game_ctrl_pkg::*;
#(
    parameter int CAR_W        = CAR_W_DEF,
    parameter int CAR_H        = CAR_H_DEF,
    parameter int OBS_W        = OBS_W_DEF,
    parameter int OBS_H        = OBS_H_DEF,
    parameter int LIVES_INIT   = LIVES_INIT_DEF,
    parameter int CRASH_FRAMES = CRASH_FRAMES_DEF,
    parameter int SCORE_MAX    = SCORE_MAX_DEF
) (
    input  logic                  iVGA_CLK,
    input  logic                  iRST,
    collision_game_ctrl_if.slave  bus
);
    // At least 3 bits so the every-8th-tick flash test is always available.
    localparam int CNT_W = ($clog2(CRASH_FRAMES + 1) < 3) ? 3 : $clog2(CRASH_FRAMES + 1);

    game_state_t      state_q, state_d;
    logic [1:0]       lives_q, lives_d;
    logic [15:0]      score_q, score_d, score_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             flash_q, flash_d;
    logic             restart_q, restart_d;
    logic             start_press;
    logic             overlap;

    key_edge_detect u_start_key (
        .iVGA_CLK  (iVGA_CLK),
        .iRST      (iRST),
        .key_n     (bus.start_n),
        .key_press (start_press)
    );

    // AABB test on zero-extended operands so right/bottom edges never wrap.
    logic [10:0] car_h, car_v, obs_h, obs_v;
    assign car_h = {1'b0, bus.car_h_pos};
    assign car_v = {2'b00, bus.car_v_pos};
    assign obs_h = {1'b0, bus.obs_h_pos};
    assign obs_v = {2'b00, bus.obs_v_pos};

    assign overlap = bus.obs_valid
                  && (car_h < obs_h + 11'(OBS_W))
                  && (obs_h < car_h + 11'(CAR_W))
                  && (car_v < obs_v + 11'(OBS_H))
                  && (obs_v < car_v + 11'(CAR_H));

    always_comb begin
`ifdef SCORE_BCD_EN
        score_inc = bcd_inc(score_q);
`else
        score_inc = (score_q >= 16'(SCORE_MAX)) ? score_q : score_q + 16'd1;
`endif
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        flash_d   = flash_q;
        restart_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A coincident frame_tick is deliberately not scored.
                if (start_press) begin
                    state_d = ST_RUN;
                    lives_d = 2'(LIVES_INIT);
                    score_d = 16'd0;
                end
            end
            ST_RUN: begin
                if (bus.frame_tick) begin
                    if (overlap) begin
                        state_d = ST_CRASH;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                        flash_d = 1'b1;
                    end else begin
                        score_d = score_inc;
                    end
                end
            end
            ST_CRASH: begin
                if (bus.frame_tick) begin
                    if (cnt_q == CNT_W'(CRASH_FRAMES - 1)) begin
                        cnt_d   = '0;
                        flash_d = 1'b0;
                        if (lives_q == 2'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d   = ST_RUN;
                            restart_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc[2:0] == 3'd0) begin
                            flash_d = ~flash_q;
                        end
                    end
                end
            end
            ST_OVER: begin
                if (start_press) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            lives_q   <= 2'(LIVES_INIT);
            score_q   <= 16'd0;
            cnt_q     <= '0;
            flash_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            cnt_q     <= cnt_d;
            flash_q   <= flash_d;
            restart_q <= restart_d;
        end
    end

    // restart_q adds a single-cycle car reset on the first RUN cycle after a crash.
    assign bus.reset_game  = (state_q == ST_IDLE) || (state_q == ST_OVER) || restart_q;
    assign bus.game_over   = (state_q == ST_OVER);
    assign bus.crash_flash = flash_q;
    assign bus.lives       = lives_q;
    assign bus.score       = score_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_collision_game_ctrl.sv
// Testbench for collision_game_ctrl: directed scenarios plus randomized play,
// compared every cycle against a frame-level game model.
module tb_collision_game_ctrl;
    localparam int CAR_W = 50, CAR_H = 80, OBS_W = 50, OBS_H = 80;
    localparam int LIVES_INIT = 3, CRASH_FRAMES = 60, SCORE_SAT = 9999;

    logic iVGA_CLK = 1'b0;
    logic iRST;
    collision_game_ctrl_if bus ();

    collision_game_ctrl dut (
        .iVGA_CLK (iVGA_CLK),
        .iRST     (iRST),
        .bus      (bus)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_state;     // 0 idle, 1 run, 2 crash, 3 over
    int       m_lives;
    int       m_score;     // frames survived, as a plain integer
    int       m_ticks;     // frame_ticks spent so far in the current crash
    bit       m_restart;
    bit [3:0] m_hist;      // start_n samples, [0] newest
    bit       m_valid = 1'b0;

    function automatic bit boxes_overlap();
        int ch = int'(bus.car_h_pos), cv = int'(bus.car_v_pos);
        int oh = int'(bus.obs_h_pos), ov = int'(bus.obs_v_pos);
        return bus.obs_valid && (ch < oh + OBS_W) && (oh < ch + CAR_W)
                             && (cv < ov + OBS_H) && (ov < cv + CAR_H);
    endfunction

    function automatic logic [15:0] score_view(input int s);
`ifdef SCORE_BCD_EN
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`else
        return 16'(s);
`endif
    endfunction

    task automatic model_step();
        // A press is seen when a released sample is followed by a pressed one,
        // two and three edges back (synchroniser + edge register delay).
        bit press = m_hist[3] & ~m_hist[2];
        bit ov    = boxes_overlap();
        if (iRST) begin
            m_state = 0; m_lives = LIVES_INIT; m_score = 0; m_ticks = 0;
            m_restart = 1'b0; m_hist = 4'b1111; m_valid = 1'b1;
        end else if (m_valid) begin
            m_restart = 1'b0;
            if (m_state == 0) begin
                if (press) begin m_state = 1; m_lives = LIVES_INIT; m_score = 0; end
            end else if (m_state == 1) begin
                if (bus.frame_tick) begin
                    if (ov) begin m_state = 2; m_lives--; m_ticks = 0; end
                    else if (m_score < SCORE_SAT) m_score++;
                end
            end else if (m_state == 2) begin
                if (bus.frame_tick) begin
                    m_ticks++;
                    if (m_ticks == CRASH_FRAMES) begin
                        if (m_lives == 0) m_state = 3;
                        else begin m_state = 1; m_restart = 1'b1; end
                    end
                end
            end else begin
                if (press) m_state = 0;
            end
            m_hist = {m_hist[2:0], bus.start_n};
        end
    endtask

    initial forever begin
        @(posedge iVGA_CLK);
        model_step();
    end

    // Per-cycle compare, away from the active edge.
    initial forever begin
        @(negedge iVGA_CLK);
        if (m_valid) begin
            check("state",       32'(bus.state),       32'(m_state));
            check("reset_game",  32'(bus.reset_game),
                  32'(m_state == 0 || m_state == 3 || m_restart));
            check("game_over",   32'(bus.game_over),   32'(m_state == 3));
            check("crash_flash", 32'(bus.crash_flash),
                  32'(m_state == 2 && ((m_ticks / 8) % 2) == 0));
            check("lives",       32'(bus.lives),       32'(m_lives));
            check("score",       32'(bus.score),       32'(score_view(m_score)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge iVGA_CLK);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            bus.frame_tick = 1'b1; step();
            bus.frame_tick = 1'b0; step();
        end
    endtask

    task automatic press_start();
        bus.start_n = 1'b0;
        repeat (5) step();
        bus.start_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic crash_once();
        bus.obs_valid = 1'b1; bus.frame_tick = 1'b1; step();
        bus.obs_valid = 1'b0; bus.frame_tick = 1'b0;
    endtask

    initial begin
        int hold = 0;
        int h, v;
        iRST = 1'b1; bus.start_n = 1'b1; bus.frame_tick = 1'b0;
        bus.car_h_pos = 10'd295; bus.car_v_pos = 9'd400;
        bus.obs_h_pos = 10'd300; bus.obs_v_pos = 9'd380; bus.obs_valid = 1'b0;
        step(); step();
        iRST = 1'b0;
        check("rst_state", 32'(bus.state), 0);
        check("rst_reset_game", 32'(bus.reset_game), 1);
        check("rst_lives", 32'(bus.lives), 3);
        check("rst_score", 32'(bus.score), 0);

        // Start press: pulse 3 edges after start_n falls, RUN one edge later.
        bus.start_n = 1'b0;
        step(); step(); step();
        check("pre_press_state", 32'(bus.state), 0);
        step();
        check("press_to_run", 32'(bus.state), 1);
        step(); bus.start_n = 1'b1; step(); step();
        tick_n(10);
        check("score_10", 32'(bus.score), 32'(score_view(10)));

        // Overlapping boxes: car(295,400) vs obs(300,380).
        crash_once();
        check("crash_state", 32'(bus.state), 2);
        check("crash_lives", 32'(bus.lives), 2);
        check("crash_score_held", 32'(bus.score), 32'(score_view(10)));
        check("crash_flash_entry", 32'(bus.crash_flash), 1);
        tick_n(59);
        check("crash_hold_59", 32'(bus.state), 2);
        bus.frame_tick = 1'b1; step(); bus.frame_tick = 1'b0;
        check("crash_exit_run", 32'(bus.state), 1);
        check("restart_pulse", 32'(bus.reset_game), 1);
        step();
        check("restart_pulse_end", 32'(bus.reset_game), 0);

        // Touching edges do not collide; one pixel further in does.
        bus.obs_h_pos = 10'd245; bus.obs_valid = 1'b1; tick_n(1); bus.obs_valid = 1'b0;
        check("touch_no_crash", 32'(bus.state), 1);
        check("touch_scored", 32'(bus.score), 32'(score_view(11)));
        bus.obs_h_pos = 10'd246;
        crash_once();
        check("overlap_1px", 32'(bus.state), 2);
        check("lives_1", 32'(bus.lives), 1);
        tick_n(60);
        crash_once();
        check("lives_0", 32'(bus.lives), 0);
        tick_n(60);
        check("over_state", 32'(bus.state), 3);
        check("over_flag", 32'(bus.game_over), 1);
        check("over_score", 32'(bus.score), 32'(score_view(11)));
        press_start();
        check("over_to_idle", 32'(bus.state), 0);
        press_start();
        check("restart_run", 32'(bus.state), 1);
        check("restart_lives", 32'(bus.lives), 3);
        check("restart_score", 32'(bus.score), 0);

        // Reset in the middle of a crash.
        crash_once();
        tick_n(10);
        iRST = 1'b1; step(); iRST = 1'b0;
        check("mid_crash_rst_state", 32'(bus.state), 0);
        check("mid_crash_rst_flash", 32'(bus.crash_flash), 0);

        // Score digit carry 99 -> 100.
        press_start();
        tick_n(99);
        check("score_99", 32'(bus.score), 32'(score_view(99)));
        tick_n(1);
        check("score_100", 32'(bus.score), 32'(score_view(100)));

        // Randomized play.
        repeat (4000) begin
            iRST = ($urandom % 400) == 0;
            bus.frame_tick = ($urandom % 3) == 0;
            if (hold > 0) begin
                bus.start_n = 1'b0; hold--;
            end else begin
                bus.start_n = 1'b1;
                if (($urandom % 40) == 0) hold = $urandom_range(1, 8);
            end
            bus.car_h_pos = 10'($urandom_range(0, 590));
            bus.car_v_pos = 9'($urandom_range(0, 400));
            if (($urandom % 4) == 0) begin
                bus.obs_h_pos = 10'($urandom_range(0, 1023));
                bus.obs_v_pos = 9'($urandom_range(0, 511));
            end else begin
                h = int'(bus.car_h_pos) + int'($urandom_range(0, 120)) - 60;
                v = int'(bus.car_v_pos) + int'($urandom_range(0, 180)) - 90;
                bus.obs_h_pos = 10'((h < 0) ? 0 : h);
                bus.obs_v_pos = 9'((v < 0) ? 0 : v);
            end
            bus.obs_valid = ($urandom % 4) != 0;
            step();
        end

        // Saturation at 9999.
        iRST = 1'b1; bus.start_n = 1'b1; bus.frame_tick = 1'b0; bus.obs_valid = 1'b0;
        step(); iRST = 1'b0;
        press_start();
        bus.frame_tick = 1'b1;
        repeat (10005) step();
        bus.frame_tick = 1'b0; step();
        check("score_saturated", 32'(bus.score), 32'(score_view(9999)));
        check("still_running", 32'(bus.state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
